// File: rtl/axis_chk32.sv
// AXI-Stream sink that checks the 32-bit block test pattern {AA,AA,AA,idx}.
// It keeps good-block, data-error and length-error statistics and captures the first failing beat.
module axis_chk32 #(
  parameter int unsigned BYTES_PER_BLOCK = 32,
  parameter int unsigned READY_MODE      = 0,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        mm2s_prmry_resetn,
  input  logic [31:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  input  logic [3:0]  s_tkeep,
  input  logic        clr_stats,
  output logic [31:0] beat_cnt,
  output logic [31:0] block_ok_cnt,
  output logic [15:0] data_err_cnt,
  output logic [15:0] len_err_cnt,
  output logic        err_sticky,
  output logic [31:0] first_err_data,
  output logic [7:0]  first_err_idx
);

  localparam int unsigned WORDS_PER_BLOCK = BYTES_PER_BLOCK / 4;
  localparam logic [7:0]  LAST_IDX        = 8'(WORDS_PER_BLOCK - 1);

  typedef enum logic {ST_DISABLED, ST_RUN} state_e;

  state_e      state_q, state_d;
  logic        tready_q, tready_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  idx_q, idx_d;
  logic        blk_err_q, blk_err_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic [31:0] block_ok_cnt_q, block_ok_cnt_d;
  logic [15:0] data_err_cnt_q, data_err_cnt_d;
  logic [15:0] len_err_cnt_q, len_err_cnt_d;
  logic        err_sticky_q, err_sticky_d;
  logic [31:0] first_err_data_q, first_err_data_d;
  logic [7:0]  first_err_idx_q, first_err_idx_d;
  logic        cap_done_q, cap_done_d;

  logic        hs, data_err, at_last, len_err, good_end;

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q          <= ST_DISABLED;
      tready_q         <= 1'b0;
      lfsr_q           <= LFSR_SEED;
      idx_q            <= 8'd0;
      blk_err_q        <= 1'b0;
      beat_cnt_q       <= 32'd0;
      block_ok_cnt_q   <= 32'd0;
      data_err_cnt_q   <= 16'd0;
      len_err_cnt_q    <= 16'd0;
      err_sticky_q     <= 1'b0;
      first_err_data_q <= 32'd0;
      first_err_idx_q  <= 8'd0;
      cap_done_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      tready_q         <= tready_d;
      lfsr_q           <= lfsr_d;
      idx_q            <= idx_d;
      blk_err_q        <= blk_err_d;
      beat_cnt_q       <= beat_cnt_d;
      block_ok_cnt_q   <= block_ok_cnt_d;
      data_err_cnt_q   <= data_err_cnt_d;
      len_err_cnt_q    <= len_err_cnt_d;
      err_sticky_q     <= err_sticky_d;
      first_err_data_q <= first_err_data_d;
      first_err_idx_q  <= first_err_idx_d;
      cap_done_q       <= cap_done_d;
    end
  end

  // Next state, ready generation, pattern check and statistics
  always_comb begin
    state_d          = state_q;
    tready_d         = 1'b0;
    lfsr_d           = lfsr_q;
    idx_d            = idx_q;
    blk_err_d        = blk_err_q;
    beat_cnt_d       = beat_cnt_q;
    block_ok_cnt_d   = block_ok_cnt_q;
    data_err_cnt_d   = data_err_cnt_q;
    len_err_cnt_d    = len_err_cnt_q;
    err_sticky_d     = err_sticky_q;
    first_err_data_d = first_err_data_q;
    first_err_idx_d  = first_err_idx_q;
    cap_done_d       = cap_done_q;

    hs       = s_tvalid && tready_q && (state_q == ST_RUN);
    at_last  = (idx_q == LAST_IDX);
    data_err = hs && ((s_tdata != {24'hAAAAAA, idx_q}) || (s_tkeep != 4'hF));
    len_err  = hs && (s_tlast != at_last);
    good_end = hs && s_tlast && at_last;

    state_d = mm2s_prmry_resetn ? ST_RUN : ST_DISABLED;

    // Fibonacci x^16+x^14+x^13+x^11+1, shifting right
    if (mm2s_prmry_resetn) begin
      lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      tready_d = (READY_MODE != 0) ? lfsr_q[0] : 1'b1;
    end

    case (state_q)
      ST_DISABLED: begin
        idx_d     = 8'd0;
        blk_err_d = 1'b0;
      end
      ST_RUN: begin
        if (hs) begin
          if (s_tlast || at_last) begin
            idx_d     = 8'd0;
            blk_err_d = 1'b0;
          end else begin
            idx_d     = idx_q + 8'd1;
            blk_err_d = blk_err_q | data_err;
          end
        end
      end
      default: begin
        idx_d     = 8'd0;
        blk_err_d = 1'b0;
      end
    endcase

    // Clearing wins over any statistic update from a coincident beat
    if (clr_stats) begin
      beat_cnt_d       = 32'd0;
      block_ok_cnt_d   = 32'd0;
      data_err_cnt_d   = 16'd0;
      len_err_cnt_d    = 16'd0;
      err_sticky_d     = 1'b0;
      first_err_data_d = 32'd0;
      first_err_idx_d  = 8'd0;
      cap_done_d       = 1'b0;
    end else if (hs) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
      if (data_err) begin
        err_sticky_d = 1'b1;
        if (data_err_cnt_q != 16'hFFFF) data_err_cnt_d = data_err_cnt_q + 16'd1;
        if (!cap_done_q) begin
          cap_done_d       = 1'b1;
          first_err_data_d = s_tdata;
          first_err_idx_d  = idx_q;
        end
      end
      if (len_err) begin
        err_sticky_d = 1'b1;
        if (len_err_cnt_q != 16'hFFFF) len_err_cnt_d = len_err_cnt_q + 16'd1;
      end
      if (good_end && !blk_err_q && !data_err) block_ok_cnt_d = block_ok_cnt_q + 32'd1;
    end
  end

  assign s_tready       = tready_q;
  assign beat_cnt       = beat_cnt_q;
  assign block_ok_cnt   = block_ok_cnt_q;
  assign data_err_cnt   = data_err_cnt_q;
  assign len_err_cnt    = len_err_cnt_q;
  assign err_sticky     = err_sticky_q;
  assign first_err_data = first_err_data_q;
  assign first_err_idx  = first_err_idx_q;

endmodule

// File: tb/tb_axis_chk32.sv
// Self-checking bench for axis_chk32: directed pattern cases plus random traffic against a behavioural model.
// A second instance with LFSR backpressure receives 100 clean blocks.
module tb_axis_chk32;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic aresetn = 1'b1;

  logic        en0 = 0, tv0 = 0, tl0 = 0, clr0 = 0;
  logic [31:0] td0 = 0;
  logic [3:0]  tk0 = 4'hF;
  logic        rdy0, st0;
  logic [31:0] beat0, ok0, fd0;
  logic [15:0] de0, le0;
  logic [7:0]  fi0;

  logic        en1 = 0, tv1 = 0, tl1 = 0, clr1 = 0;
  logic [31:0] td1 = 0;
  logic [3:0]  tk1 = 4'hF;
  logic        rdy1, st1;
  logic [31:0] beat1, ok1, fd1;
  logic [15:0] de1, le1;
  logic [7:0]  fi1;

  axis_chk32 #(.BYTES_PER_BLOCK(32), .READY_MODE(0), .LFSR_SEED(16'hACE1)) dut0 (
    .aclk(clk), .aresetn(aresetn), .mm2s_prmry_resetn(en0),
    .s_tdata(td0), .s_tvalid(tv0), .s_tready(rdy0), .s_tlast(tl0), .s_tkeep(tk0),
    .clr_stats(clr0), .beat_cnt(beat0), .block_ok_cnt(ok0), .data_err_cnt(de0),
    .len_err_cnt(le0), .err_sticky(st0), .first_err_data(fd0), .first_err_idx(fi0));

  axis_chk32 #(.BYTES_PER_BLOCK(32), .READY_MODE(1), .LFSR_SEED(16'hACE1)) dut1 (
    .aclk(clk), .aresetn(aresetn), .mm2s_prmry_resetn(en1),
    .s_tdata(td1), .s_tvalid(tv1), .s_tready(rdy1), .s_tlast(tl1), .s_tkeep(tk1),
    .clr_stats(clr1), .beat_cnt(beat1), .block_ok_cnt(ok1), .data_err_cnt(de1),
    .len_err_cnt(le1), .err_sticky(st1), .first_err_data(fd1), .first_err_idx(fi1));

  int errors = 0;
  int checks = 0;
  logic cmp_on = 0;
  logic done1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of dut0: what the statistics must be after each accepted beat
  logic        m_run = 0, m_blk = 0, m_sticky = 0, m_cap = 0;
  int unsigned m_idx = 0;
  logic [31:0] m_beat = 0, m_ok = 0, m_fd = 0;
  logic [15:0] m_de = 0, m_le = 0;
  logic [7:0]  m_fi = 0;

  initial forever begin
    @(posedge clk);
    if (!aresetn) begin
      m_run = 0; m_blk = 0; m_sticky = 0; m_cap = 0; m_idx = 0;
      m_beat = 0; m_ok = 0; m_fd = 0; m_de = 0; m_le = 0; m_fi = 0;
    end else begin
      if (m_run && tv0) begin
        logic bad, lastpos;
        bad     = (td0 !== {24'hAAAAAA, 8'(m_idx)}) || (tk0 !== 4'hF);
        lastpos = (m_idx == W - 1);
        if (!clr0) begin
          m_beat = m_beat + 1;
          if (bad) begin
            if (m_de != 16'hFFFF) m_de = m_de + 1;
            m_sticky = 1;
            if (!m_cap) begin m_cap = 1; m_fd = td0; m_fi = 8'(m_idx); end
          end
          if (tl0 != lastpos) begin
            if (m_le != 16'hFFFF) m_le = m_le + 1;
            m_sticky = 1;
          end else if (tl0 && !m_blk && !bad) begin
            m_ok = m_ok + 1;
          end
        end
        if (tl0 || lastpos) begin m_idx = 0; m_blk = 0; end
        else begin m_idx = m_idx + 1; m_blk = m_blk || bad; end
      end else if (!m_run) begin
        m_idx = 0; m_blk = 0;
      end
      if (clr0) begin
        m_beat = 0; m_ok = 0; m_de = 0; m_le = 0; m_sticky = 0; m_fd = 0; m_fi = 0; m_cap = 0;
      end
      m_run = en0;
    end
  end

  // Reference ready sequence for dut1: LFSR x^16+x^14+x^13+x^11+1 bit 0
  logic [15:0] m_lfsr = 16'hACE1;
  logic        m_rdy1 = 0;
  int          rdy1_lows = 0;

  initial forever begin
    @(posedge clk);
    if (!aresetn) begin
      m_lfsr = 16'hACE1; m_rdy1 = 0;
    end else begin
      m_rdy1 = en1 ? m_lfsr[0] : 1'b0;
      if (en1) m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
  end

  // Per-cycle comparison of both instances against the models
  initial forever begin
    @(negedge clk);
    if (aresetn && cmp_on) begin
      chk("tready0", 32'(rdy0), 32'(m_run));
      chk("beat_cnt", beat0, m_beat);
      chk("block_ok_cnt", ok0, m_ok);
      chk("data_err_cnt", 32'(de0), 32'(m_de));
      chk("len_err_cnt", 32'(le0), 32'(m_le));
      chk("err_sticky", 32'(st0), 32'(m_sticky));
      chk("first_err_data", fd0, m_fd);
      chk("first_err_idx", 32'(fi0), 32'(m_fi));
      chk("tready1", 32'(rdy1), 32'(m_rdy1));
      if (en1 && !rdy1) rdy1_lows++;
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic last, input logic [3:0] keep, input logic clr);
    int n;
    @(negedge clk);
    td0 = d; tl0 = last; tk0 = keep; tv0 = 1; clr0 = clr;
    n = 0;
    while (!rdy0 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_beat timeout: tready0 low for %0d cycles, required high", n);
    end
    @(posedge clk);
  endtask

  task automatic idle0();
    @(negedge clk);
    tv0 = 0; tl0 = 0; clr0 = 0; tk0 = 4'hF;
  endtask

  task automatic send_block(input int nbeats, input int last_at, input int bad_at,
                            input logic [31:0] bad_data, input logic bad_keep, input int clr_at);
    for (int k = 0; k < nbeats; k++) begin
      logic [31:0] d;
      logic [3:0]  kp;
      d  = {24'hAAAAAA, 8'(k)};
      kp = 4'hF;
      if (k == bad_at) begin
        if (bad_keep) kp = 4'h7;
        else d = bad_data;
      end
      send_beat(d, (k == last_at), kp, (k == clr_at));
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    tv0 = 0; clr0 = 1;
    @(negedge clk);
    clr0 = 0;
  endtask

  task automatic bounce_enable(input int gap);
    @(negedge clk);
    tv0 = 0; tl0 = 0; clr0 = 0; en0 = 0;
    repeat (gap) @(negedge clk);
    en0 = 1;
  endtask

  // Backpressured instance: 100 clean blocks, tvalid held while tready is low
  initial begin
    @(posedge aresetn);
    @(negedge clk);
    en1 = 1;
    @(negedge clk); chk("lfsr_rdy_0", 32'(rdy1), 32'd1);
    @(negedge clk); chk("lfsr_rdy_1", 32'(rdy1), 32'd0);
    @(negedge clk); chk("lfsr_rdy_2", 32'(rdy1), 32'd0);
    for (int b = 0; b < 100; b++) begin
      for (int k = 0; k < int'(W); k++) begin
        int n;
        @(negedge clk);
        td1 = {24'hAAAAAA, 8'(k)}; tl1 = (k == int'(W) - 1); tv1 = 1;
        n = 0;
        while (!rdy1 && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) begin
          checks++; errors++;
          $display("FAIL dut1 beat timeout: tready1 low for %0d cycles, required high", n);
        end
        @(posedge clk);
      end
      if ($urandom_range(0, 3) == 0) begin @(negedge clk); tv1 = 0; tl1 = 0; end
    end
    @(negedge clk); tv1 = 0; tl1 = 0;
    @(negedge clk);
    chk("dut1 block_ok_cnt", ok1, 32'd100);
    chk("dut1 beat_cnt", beat1, 32'd800);
    chk("dut1 data_err_cnt", 32'(de1), 32'd0);
    chk("dut1 len_err_cnt", 32'(le1), 32'd0);
    chk("dut1 err_sticky", 32'(st1), 32'd0);
    chk("dut1 tready toggled", 32'(rdy1_lows > 0), 32'd1);
    done1 = 1;
  end

  initial begin
    int guard;
    #2 aresetn = 0;
    #20;
    chk("reset tready0", 32'(rdy0), 32'd0);
    chk("reset beat_cnt", beat0, 32'd0);
    chk("reset block_ok_cnt", ok0, 32'd0);
    chk("reset data_err_cnt", 32'(de0), 32'd0);
    chk("reset len_err_cnt", 32'(le0), 32'd0);
    chk("reset err_sticky", 32'(st0), 32'd0);
    chk("reset first_err_data", fd0, 32'd0);
    chk("reset first_err_idx", 32'(fi0), 32'd0);
    chk("reset tready1", 32'(rdy1), 32'd0);
    @(negedge clk);
    aresetn = 1;
    cmp_on  = 1;
    @(negedge clk);
    en0 = 1;

    // Three clean blocks back-to-back
    repeat (3) send_block(8, 7, -1, 32'd0, 0, -1);
    idle0();
    chk("t1 block_ok_cnt", ok0, 32'd3);
    chk("t1 beat_cnt", beat0, 32'd24);
    chk("t1 data_err_cnt", 32'(de0), 32'd0);
    chk("t1 err_sticky", 32'(st0), 32'd0);

    // Corrupt beat 5, then a clean block
    pulse_clr();
    send_block(8, 7, 5, 32'hAAAAAA07, 0, -1);
    idle0();
    chk("t2 data_err_cnt", 32'(de0), 32'd1);
    chk("t2 first_err_data", fd0, 32'hAAAAAA07);
    chk("t2 first_err_idx", 32'(fi0), 32'd5);
    chk("t2 block_ok_cnt", ok0, 32'd0);
    send_block(8, 7, -1, 32'd0, 0, -1);
    idle0();
    chk("t2 block_ok_cnt after", ok0, 32'd1);

    // Early tlast on beat 3, then a clean block
    pulse_clr();
    send_block(4, 3, -1, 32'd0, 0, -1);
    send_block(8, 7, -1, 32'd0, 0, -1);
    idle0();
    chk("t3 len_err_cnt", 32'(le0), 32'd1);
    chk("t3 block_ok_cnt", ok0, 32'd1);

    // Nine beats without tlast
    pulse_clr();
    send_block(9, -1, -1, 32'd0, 0, -1);
    idle0();
    chk("t4 len_err_cnt", 32'(le0), 32'd1);
    chk("t4 data_err_cnt", 32'(de0), 32'd1);
    chk("t4 first_err_idx", 32'(fi0), 32'd0);
    chk("t4 first_err_data", fd0, 32'hAAAAAA08);

    // Mid-block disable discards the partial block silently
    bounce_enable(2);
    pulse_clr();
    send_block(3, -1, -1, 32'd0, 0, -1);
    bounce_enable(3);
    send_block(8, 7, -1, 32'd0, 0, -1);
    idle0();
    chk("t5 len_err_cnt", 32'(le0), 32'd0);
    chk("t5 data_err_cnt", 32'(de0), 32'd0);
    chk("t5 block_ok_cnt", ok0, 32'd1);

    // Clear coinciding with a handshake
    send_block(2, -1, -1, 32'd0, 0, 1);
    idle0();
    chk("t6 beat_cnt after clr", beat0, 32'd0);
    chk("t6 block_ok_cnt after clr", ok0, 32'd0);
    for (int k = 2; k < 8; k++) send_beat({24'hAAAAAA, 8'(k)}, (k == 7), 4'hF, 0);
    idle0();
    chk("t6 beat_cnt", beat0, 32'd6);
    chk("t6 block_ok_cnt", ok0, 32'd1);

    // Random traffic checked cycle by cycle against the model
    for (int i = 0; i < 120; i++) begin
      int kind;
      kind = int'($urandom_range(0, 11));
      case (kind)
        0, 1, 2, 3: send_block(8, 7, -1, 32'd0, 0, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1);
        4: send_block(8, 7, int'($urandom_range(0, 7)),
                      {24'hAAAAAA, 8'($urandom_range(0, 7))} ^ (32'd1 << $urandom_range(8, 31)), 0, -1);
        5: send_block(8, 7, int'($urandom_range(0, 7)), 32'd0, 1, -1);
        6: send_block(8, int'($urandom_range(0, 6)), -1, 32'd0, 0, -1);
        7: send_block(int'($urandom_range(8, 10)), -1, -1, 32'd0, 0, -1);
        8: begin
          send_block(int'($urandom_range(1, 6)), -1, -1, 32'd0, 0, -1);
          bounce_enable(int'($urandom_range(1, 3)));
        end
        9: pulse_clr();
        default: repeat ($urandom_range(1, 4)) idle0();
      endcase
    end
    idle0();

    guard = 0;
    while (!done1 && guard < 20000) begin @(negedge clk); guard++; end
    if (!done1) begin
      checks++; errors++;
      $display("FAIL dut1 completion: done=%0d after %0d cycles, required 1", done1, guard);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_chk32.md
Name: axis_chk32

Overview:
- AXI-Stream sink and pattern checker; receiving end of the 32-bit block test pattern.
- Fed by the DMA MM2S channel with data the S2MM path previously wrote.
- Expects beat k of every block to be {8'hAA,8'hAA,8'hAA,k[7:0]}, with TLAST on beat WORDS_PER_BLOCK-1.
- Counts good blocks, data errors and length errors, and captures the first failing beat for software readback.

Parameters:
- BYTES_PER_BLOCK, 32, block length in bytes; multiple of 4; WORDS_PER_BLOCK = BYTES_PER_BLOCK/4, range 1..256.
- READY_MODE, 0, 0 = tready always high when enabled; 1 = tready driven by an LFSR for backpressure testing.
- LFSR_SEED, 16'hACE1, non-zero seed for the READY_MODE=1 LFSR.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- mm2s_prmry_resetn  in  1  enable: 1 = MM2S channel running.
- s_tdata  in  32  stream data.
- s_tvalid  in  1  stream valid.
- s_tready  out  1  stream ready, registered.
- s_tlast  in  1  end of block.
- s_tkeep  in  4  byte enables.
- clr_stats  in  1  synchronous one-cycle pulse: clear statistics.
- beat_cnt  out  32  accepted beats.
- block_ok_cnt  out  32  error-free complete blocks.
- data_err_cnt  out  16  beats with tdata/tkeep mismatch; saturates at 16'hFFFF.
- len_err_cnt  out  16  length errors; saturates at 16'hFFFF.
- err_sticky  out  1  set on any error; held until clr_stats or reset.
- first_err_data  out  32  tdata of the first data-error beat.
- first_err_idx  out  8  expected index of that beat.

Behaviour:
- Reset (aresetn low, asynchronous):
  - All outputs, counters, the index register idx, blk_err and captures go to 0.
  - The LFSR loads LFSR_SEED.
- Handshake: hs = s_tvalid && s_tready. Only hs cycles are examined; s_tready may drop while s_tvalid is high.
- s_tready:
  - 0 while disabled.
  - When enabled with READY_MODE=0: 1 from the cycle after the enable is first seen high.
  - When enabled with READY_MODE=1: s_tready <= lfsr[0] each cycle. The LFSR is Fibonacci x^16+x^14+x^13+x^11+1 and advances every enabled cycle.
- States:
  - DISABLED (mm2s_prmry_resetn=0): s_tready=0, idx=0, blk_err=0. Statistics and captures are retained.
  - RUN: entered the cycle after the enable is seen high.
  - Enable deassert mid-block: return to DISABLED next cycle. The partial block is discarded with no length error.
- Per hs in RUN, with exp = {24'hAAAAAA, idx}:
  - beat_cnt += 1 (wraps).
  - Data error: (s_tdata != exp) || (s_tkeep != 4'hF). Effects: data_err_cnt += 1, blk_err=1, err_sticky=1. If this is the first error since clear, capture first_err_data=s_tdata and first_err_idx=idx.
  - Early end: s_tlast=1 with idx < WORDS_PER_BLOCK-1. Effects: len_err_cnt += 1, err_sticky=1, block not counted, idx <= 0 (resync), blk_err <= 0.
  - Missing end: s_tlast=0 with idx = WORDS_PER_BLOCK-1. Effects: len_err_cnt += 1, err_sticky=1, block not counted, idx <= 0, blk_err <= 0.
  - Correct end: s_tlast=1 with idx = WORDS_PER_BLOCK-1. If no data error occurred in the block, including this beat, block_ok_cnt += 1. Then idx <= 0, blk_err <= 0.
  - Otherwise: idx <= idx + 1.
  - One beat may increment both data_err_cnt and len_err_cnt.
- clr_stats:
  - Clears beat_cnt, block_ok_cnt, data_err_cnt, len_err_cnt, err_sticky and the captures; clearing takes priority.
  - An hs in the same cycle updates idx/blk_err normally but is not added to any statistic.
  - idx is not reset by clr_stats.
- Latency: statistic outputs update on the clock edge after the hs cycle.
- WORDS_PER_BLOCK=1: every beat needs s_tlast=1 and expected low byte 0.

Test Plan:
- Reset, enable, READY_MODE=0, send 3 correct 8-beat blocks back-to-back -> s_tready=1 throughout, block_ok_cnt=3, beat_cnt=24, all error counts 0, err_sticky=0.
- Beat 5 of block 1 has tdata=32'hAAAAAA07 -> data_err_cnt=1, first_err_data=32'hAAAAAA07, first_err_idx=5, block_ok_cnt=0; the next correct block gives block_ok_cnt=1.
- s_tlast on beat 3 (early), then a correct block -> len_err_cnt=1, resync; block_ok_cnt=1 after the second block.
- 9-beat burst with no tlast on beat 7 -> len_err_cnt=1 at beat 7; beat 8 carries low byte 8 against expected 0, giving data_err_cnt=1 and a capture with idx 0.
- READY_MODE=1, source holds tvalid through backpressure while sending 100 blocks -> block_ok_cnt=100, no errors, s_tready toggles per the LFSR.
- Drop enable mid-block, re-enable, send a full block -> no length error, block_ok_cnt +1. clr_stats pulsed together with an hs -> all counters 0 next cycle.
